// File: rtl/add_arbiter_if.sv
// add_arbiter bus: requesters, response channel and shared adder port.
// slave = arbiter side, master = environment side.
interface add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) ();
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [W+2:0]       rsp_sum;
  logic               rsp_ready;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic               add_valid;
  logic               add_rst;
  logic [W+2:0]       add_c;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b,
    input  rsp_ready, add_c,
    output req_ready, rsp_valid,
    output rsp_id, rsp_sum,
    output add_a, add_b,
    output add_valid, add_rst, busy
  );

  modport master (
    output req_valid, req_a, req_b,
    output rsp_ready, add_c,
    input  req_ready, rsp_valid,
    input  rsp_id, rsp_sum,
    input  add_a, add_b,
    input  add_valid, add_rst, busy
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among N_REQ requesters.
// One operation in flight: accept, EXEC, LOAD, CAPT, RESP.
module add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input logic        clk,
  input logic        reset,
  add_arbiter_if.slave arb
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [IW:0] LP_N =
    (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LP_LAST =
    IW'(N_REQ-1);

  typedef enum logic [2:0] {
    IDLE, EXEC, LOAD, CAPT, RESP
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W+2:0]     r_sum;
  logic             r_rsp_valid;
  logic             r_add_valid;
  logic             r_add_rst;
  logic             r_busy;

  logic [IW-1:0]    w_win;
  logic [IW:0]      w_idx;
  logic             w_found;
  logic             w_go;
  logic [N_REQ-1:0] w_grant;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;

  // first requester at or after r_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + k[IW:0];
      if (w_idx >= LP_N)
        w_idx = w_idx - LP_N;
      if (!w_found &&
          arb.req_valid[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  // accept only in IDLE, never while the adder is in reset
  assign w_go = (r_state == IDLE) &&
                !r_add_rst && w_found;
  assign w_grant = w_go ?
    (N_REQ'(1) << w_win) : '0;
  assign w_a = arb.req_a[w_win*W +: W];
  assign w_b = arb.req_b[w_win*W +: W];

  // operation sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_rsp_valid <= 1'b0;
      r_add_valid <= 1'b0;
      r_add_rst   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_add_rst <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_a         <= w_a;
            r_b         <= w_b;
            r_id        <= w_win;
            r_add_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_add_valid <= 1'b0;
          r_state     <= LOAD;
        end
        LOAD: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_sum       <= {2'b00, arb.add_c[W:0]};
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (arb.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
            r_ptr       <= (r_id == LP_LAST) ?
                           '0 : r_id + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arb.req_ready = w_grant;
  assign arb.rsp_valid = r_rsp_valid;
  assign arb.rsp_id    = r_id;
  assign arb.rsp_sum   = r_sum;
  assign arb.add_a     = r_a;
  assign arb.add_b     = r_b;
  assign arb.add_valid = r_add_valid;
  assign arb.add_rst   = r_add_rst;
  assign arb.busy      = r_busy;
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL be the number of requesters; legal values 2..8.
REQ-002 Parameter W, default 4, SHALL be the operand width; the result width SHALL be W+3.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  SHALL carry the per-requester operation request.
REQ-006 req_a, req_b  input  N_REQ*W each  SHALL carry the operands; requester i SHALL use bits [i*W +: W].
REQ-007 req_ready  output  N_REQ  SHALL be the one-hot acceptance strobe.
REQ-008 rsp_valid  output  1  SHALL indicate that a result is presented.
REQ-009 rsp_id  output  clog2(N_REQ)  SHALL give the index of the requester that owns the result.
REQ-010 rsp_sum  output  W+3  SHALL carry the result.
REQ-011 rsp_ready  input  1  SHALL be the consumer acceptance signal.
REQ-012 add_a, add_b  output  W each, and add_valid  output  1, SHALL drive the shared adder.
REQ-013 add_rst  output  1  SHALL drive the adder's synchronous active-high reset.
REQ-014 add_c  input  W+3  SHALL return the adder result.
REQ-015 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, EXEC, LOAD, CAPT and RESP.
REQ-017 In IDLE with any req_valid bit high, req_ready SHALL be driven combinationally high for exactly one winner.
- Winner = first set bit at or after rr_ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-018 At that edge, the block SHALL latch the winner's operands and id, and the FSM SHALL go to EXEC.
REQ-019 EXEC SHALL last one cycle with add_valid=1 and add_a/add_b equal to the latched operands, then go to LOAD.
REQ-020 LOAD SHALL last one cycle with add_valid=0 and operands held, then go to CAPT.
REQ-021 CAPT SHALL register add_c into rsp_sum, then go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1, with rsp_sum and rsp_id stable until rsp_ready is sampled high.
- On that edge the FSM SHALL go to IDLE and rr_ptr SHALL become (winner+1) mod N_REQ.
REQ-023 No request SHALL be accepted in the cycle that RESP exits, so the minimum spacing between acceptances is 5 cycles.
REQ-024 rsp_valid SHALL rise after the 3rd rising edge following the acceptance edge, when rsp_ready is held high.
REQ-025 rsp_sum SHALL equal the zero-extended sum req_a+req_b; the upper 2 bits SHALL always be 0.
REQ-026 Outside EXEC, add_valid SHALL be 0. In IDLE, add_a and add_b SHALL hold their last values.
REQ-027 req_valid changes on non-winning requesters SHALL NOT affect an in-flight operation.
REQ-028 rr_ptr SHALL change only when a response completes.

Reset
REQ-029 While reset is 0, the block SHALL hold the following values:
- FSM=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, add_valid=0, add_a=0, add_b=0, busy=0.
REQ-030 add_rst SHALL be 1 while reset is 0 and for exactly one clk cycle after reset deasserts; no request SHALL be accepted in that cycle.
REQ-031 Reset asserted mid-operation SHALL abort the operation immediately; no rsp_valid SHALL be produced for it.

Verification
REQ-032 Single request: req0 with a=4'hF, b=4'hF -> rsp_valid after 3 edges, rsp_sum=7'd30, rsp_id=0.
REQ-033 All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_sum is correct.
REQ-034 Backpressure: rsp_ready=0 for 6 cycles -> rsp_valid, rsp_sum and rsp_id are stable; no req_ready pulse occurs.
REQ-035 Reset pulled low in LOAD -> all outputs take their reset values asynchronously; add_rst is high for 1 cycle after release; rr_ptr=0.
REQ-036 Only req2 and req0 request, rr_ptr=3 -> req0 is granted first, then req2.
